// File: rtl/timestamp_capture_pkg.sv
// Shared definitions for the timestamp capture block: default widths,
// synchroniser depth, the drop-counter type and its update rule.
package timestamp_capture_pkg;

    // Default timestamp width; must match the upstream free-running counter.
    localparam int TS_WIDTH         = 32;
    localparam int FIFO_DEPTH       = 16;
    localparam int LAT_COMP_DEFAULT = 2;
    localparam int DROP_CNT_W       = 8;
    localparam int SYNC_STAGES      = 2;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = '1;

    // One cycle's worth of FIFO activity, resolved from event, pop and full state.
    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_op_t;

    // Next dropped-event count: a drop beats a clear in the same cycle, and the
    // count sticks at its maximum rather than wrapping.
    function automatic drop_cnt_t drop_cnt_next(input drop_cnt_t cur,
                                                input logic      drop,
                                                input logic      clr);
        drop_cnt_t nxt;
        nxt = cur;
        if (drop) begin
            if (clr) begin
                nxt = drop_cnt_t'(1);
            end else if (cur != DROP_CNT_MAX) begin
                nxt = cur + drop_cnt_t'(1);
            end
        end else if (clr) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous 1-bit input into the clk domain and emits a
// one-cycle pulse on each rising edge. After reset the input must be seen low
// before any edge is reported, so a level that was already high across reset
// is not mistaken for a new event.
module sync_edge_detect
    import timestamp_capture_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;   // [0] = s1 (metastable stage), [N-1] = s2
    logic [SYNC_STAGES-1:0] fill_q;   // shifts in ones; top bit set once s2 holds a real sample
    logic                   s3;       // previous synchronised level
    logic                   armed;    // a genuine low has been seen since reset

    logic s2;
    assign s2 = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, edge history and arming after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            fill_q <= '0;
            s3     <= 1'b0;
            armed  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value; blocking here would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            s3     <= s2;
            armed  <= armed | (fill_q[SYNC_STAGES-1] & ~s2);
        end
    end

    assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/timestamp_capture.sv
// Captures the upstream counter on each rising edge of an asynchronous event,
// corrects for synchroniser latency, and queues the result in a small
// first-word-fall-through FIFO drained by a pop handshake. Events arriving
// while the FIFO is full are dropped and counted.
module timestamp_capture
    import timestamp_capture_pkg::*;
#(
    parameter int WIDTH    = TS_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,   // power of 2, 2..256
    parameter int LAT_COMP = LAT_COMP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      count,
    input  logic                  evt,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      ts_data,
    output logic                  ts_valid,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   occ_t;

    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    ptr_t             rd_ptr_nxt;
    occ_t             occ;
    occ_t             occ_nxt;
    logic             evt_rise;
    fifo_op_t         op;
    logic [WIDTH-1:0] wr_value;
    logic [WIDTH-1:0] head_nxt;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (evt),
        .rise     (evt_rise)
    );

    // The count has advanced LAT_COMP ticks since the event was first
    // sampled; subtract it back out, wrapping modulo 2^WIDTH.
    assign wr_value = count - WIDTH'(LAT_COMP);

    // Resolve this cycle's push/pop/drop and the next occupancy and head word.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        op         = '0;
        head_nxt   = '0;
        op.pop     = rd_en & ts_valid;
        op.push    = evt_rise & (~fifo_full | op.pop);
        op.drop    = evt_rise & fifo_full & ~op.pop;
        occ_nxt    = occ + occ_t'(op.push) - occ_t'(op.pop);
        rd_ptr_nxt = rd_ptr + ptr_t'(op.pop);
        if (occ_nxt != '0) begin
            // A write into a FIFO that is empty after this cycle's pop
            // becomes the new head directly; otherwise the head is in storage.
            if (op.push && (occ - occ_t'(op.pop)) == '0) begin
                head_nxt = wr_value;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Timestamp storage.
    // NOTE: the array has no reset; entries are only read behind the
    // occupancy count, so resetting them would only cost flops.
    always_ff @(posedge clk) begin
        if (op.push) begin
            mem[wr_ptr] <= wr_value;
        end
    end

    // Pointers, occupancy and the registered head/flag outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            ts_data   <= '0;
            ts_valid  <= 1'b0;
            fifo_full <= 1'b0;
        end else begin
            if (op.push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            occ       <= occ_nxt;
            ts_data   <= head_nxt;
            ts_valid  <= (occ_nxt != '0);
            fifo_full <= (occ_nxt == occ_t'(DEPTH));
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop wins over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (op.drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            drop_cnt <= drop_cnt_next(drop_cnt, op.drop, ovf_clr);
        end
    end

endmodule

// File: tb/tb_timestamp_capture.sv
// Self-checking bench for timestamp_capture. A reference model works purely in
// terms of event times: an event first sampled high at clock N is written at
// clock N+2 with the count then present minus LAT_COMP, into a queue that is
// popped, filled and overflowed by the block's rules.
module tb_timestamp_capture;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] count = '0;
    logic             evt = 1'b0;
    logic             rd_en = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] ts_data;
    logic             ts_valid;
    logic             fifo_full;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    timestamp_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT_COMP(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .count     (count),
        .evt       (evt),
        .rd_en     (rd_en),
        .ovf_clr   (ovf_clr),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] mq[$];     // queued timestamps, head at index 0
    int               pend[$];   // clock numbers at which captures are due
    int               cyc;
    bit               m_prev;
    bit               m_armed;
    bit               m_ovf;
    int               m_drops;

    always @(posedge clk or negedge reset_n) begin
        bit due;
        bit popped;
        bit dropped;
        if (!reset_n) begin
            mq.delete();
            pend.delete();
            cyc     = 0;
            m_prev  = 1'b0;
            m_armed = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            cyc++;
            due = (pend.size() > 0) && (pend[0] == cyc);
            if (due) void'(pend.pop_front());
            popped = rd_en && (mq.size() > 0);
            if (popped) void'(mq.pop_front());
            dropped = 1'b0;
            if (due) begin
                if (mq.size() < DEPTH) mq.push_back(WIDTH'(count - LAT));
                else dropped = 1'b1;
            end
            if (dropped) begin
                m_ovf   = 1'b1;
                m_drops = ovf_clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (evt && !m_prev && m_armed) pend.push_back(cyc + 2);
            if (!evt) m_armed = 1'b1;
            m_prev = evt;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance to the next falling edge; the counter ramps by one per clock.
    task automatic tick();
        @(negedge clk);
        count = count + 1;
    endtask

    task automatic send_event(input int hi, input int lo);
        evt = 1'b1;
        repeat (hi) tick();
        evt = 1'b0;
        repeat (lo) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        evt = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({ts_valid, fifo_full, overflow, drop_cnt, ts_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b full=%b ovf=%b drops=%0d data=%h, expected all zero",
                     ts_valid, fifo_full, overflow, drop_cnt, ts_data);
        end
        reset_n = 1'b1;
        repeat (4) tick();
        vectors++;
        if (ts_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_valid: got %b expected 0", ts_valid);
        end
    endtask

    task automatic test_single_event();
        count = 100;
        evt = 1'b1;
        tick();             // posedge N samples evt, count=100
        tick();             // posedge N+1
        vectors++;
        if (ts_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_valid: got %b expected 0 before write", ts_valid);
        end
        tick();             // posedge N+2 writes count(102)-2
        vectors++;
        if (ts_valid !== 1'b1 || ts_data !== 32'd100) begin
            miscompares++;
            $display("FAIL single_capture: got valid=%b data=%0d expected valid=1 data=100", ts_valid, ts_data);
        end
        evt = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (ts_valid !== 1'b0 || mq.size() != 0) begin
            miscompares++;
            $display("FAIL single_pop: got valid=%b model_size=%0d expected empty", ts_valid, mq.size());
        end
    endtask

    task automatic test_burst_drain();
        logic [WIDTH-1:0] prev;
        for (int i = 0; i < 8; i++) send_event(5, 5);
        vectors++;
        if (ts_valid !== 1'b1 || mq.size() != 8 || ts_data !== mq[0]) begin
            miscompares++;
            $display("FAIL burst_fill: got valid=%b data=%h expected 8 queued, head=%h",
                     ts_valid, ts_data, (mq.size() > 0) ? mq[0] : '0);
        end
        rd_en = 1'b1;
        prev = ts_data;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                vectors++;
                if (ts_valid !== 1'b1 || (ts_data - prev) !== 32'd10 || ts_data !== mq[0]) begin
                    miscompares++;
                    $display("FAIL burst_spacing[%0d]: got valid=%b data=%0d prev=%0d expected step 10, model=%0d",
                             i, ts_valid, ts_data, prev, mq[0]);
                end
                prev = ts_data;
            end
        end
        rd_en = 1'b0;
        vectors++;
        if (ts_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_empty: got valid=%b expected 0 after 8 pops", ts_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 3; i++) send_event($urandom_range(2, 4), $urandom_range(2, 4));
        repeat (3) tick();
        vectors++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL overflow_flags: got full=%b ovf=%b drops=%0d expected 1 1 3", fifo_full, overflow, drop_cnt);
        end
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (ts_valid !== 1'b1 || mq.size() == 0 || ts_data !== mq[0]) begin
                miscompares++;
                $display("FAIL overflow_entry[%0d]: got valid=%b data=%h expected %h",
                         i, ts_valid, ts_data, (mq.size() > 0) ? mq[0] : '0);
            end
            tick();
        end
        rd_en = 1'b0;
        vectors++;
        if (ts_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drained: got valid=%b ovf=%b expected 0 1", ts_valid, overflow);
        end
    endtask

    task automatic test_full_pop_write();
        logic [WIDTH-1:0] last_exp;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_event(2, 2);
        tick();
        vectors++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_setup: got full=%b ovf=%b expected 1 0", fifo_full, overflow);
        end
        evt = 1'b1;
        tick();             // N
        tick();             // N+1
        rd_en = 1'b1;
        last_exp = count - LAT;   // count present at N+2
        tick();             // N+2: pop and write together
        rd_en = 1'b0;
        evt = 1'b0;
        vectors++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL fullpop_nodrop: got full=%b ovf=%b drops=%0d expected 1 0 0", fifo_full, overflow, drop_cnt);
        end
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                vectors++;
                if (ts_data !== last_exp) begin
                    miscompares++;
                    $display("FAIL fullpop_last: got %h expected %h", ts_data, last_exp);
                end
            end
            vectors++;
            if (ts_valid !== 1'b1 || mq.size() == 0 || ts_data !== mq[0]) begin
                miscompares++;
                $display("FAIL fullpop_entry[%0d]: got valid=%b data=%h expected %h",
                         i, ts_valid, ts_data, (mq.size() > 0) ? mq[0] : '0);
            end
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        repeat (3) tick();
        count = 32'hFFFF_FFFE;    // count = 0 at the write edge
        evt = 1'b1;
        repeat (3) tick();
        vectors++;
        if (ts_valid !== 1'b1 || ts_data !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL wrap_count0: got valid=%b data=%h expected fffffffe", ts_valid, ts_data);
        end
        evt = 1'b0;
        repeat (3) tick();
        count = 32'hFFFF_FFFF;    // count = 1 at the write edge
        evt = 1'b1;
        repeat (3) tick();
        evt = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (ts_valid !== 1'b1 || ts_data !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_count1: got valid=%b data=%h expected ffffffff", ts_valid, ts_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_drop_saturation();
        for (int i = 0; i < DEPTH + 262; i++) send_event(2, 2);
        tick();
        vectors++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || drop_cnt !== 8'(m_drops)) begin
            miscompares++;
            $display("FAIL drop_saturate: got drops=%0d ovf=%b expected 255 1", drop_cnt, overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_clear: got drops=%0d ovf=%b expected 0 0", drop_cnt, overflow);
        end
        rd_en = 1'b1;
        repeat (DEPTH + 1) tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 5; i++) send_event(2, 2);
        evt = 1'b1;
        tick();
        vectors++;
        if (mq.size() != 5 || ts_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_setup: got valid=%b model_size=%0d expected 5 queued", ts_valid, mq.size());
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({ts_valid, fifo_full, overflow, drop_cnt, ts_data} !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: got valid=%b full=%b ovf=%b drops=%0d data=%h expected all zero",
                     ts_valid, fifo_full, overflow, drop_cnt, ts_data);
        end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        vectors++;
        if (ts_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_spurious: got valid=%b expected 0 with evt held high", ts_valid);
        end
        evt = 1'b0;
        repeat (3) tick();
        evt = 1'b1;
        repeat (3) tick();
        evt = 1'b0;
        vectors++;
        if (ts_valid !== 1'b1 || mq.size() != 1 || ts_data !== mq[0]) begin
            miscompares++;
            $display("FAIL midreset_rearm: got valid=%b data=%h expected one entry %h",
                     ts_valid, ts_data, (mq.size() > 0) ? mq[0] : '0);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        // Two drops, then a drop coinciding with ovf_clr.
        for (int i = 0; i < DEPTH + 2; i++) send_event(2, 2);
        vectors++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL clrdrop_setup: got ovf=%b drops=%0d expected 1 2", overflow, drop_cnt);
        end
        evt = 1'b1;
        tick();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        evt = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL clr_vs_drop: got ovf=%b drops=%0d expected 1 1", overflow, drop_cnt);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        rd_en = 1'b1;
        repeat (DEPTH + 1) tick();
        rd_en = 1'b0;
        vectors++;
        if (ts_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL clrdrop_final: got valid=%b ovf=%b drops=%0d expected 0 0 0", ts_valid, overflow, drop_cnt);
        end
    endtask

    task automatic test_random();
        int          phase_left = 3;
        int          rd_pct;
        logic [10:0] exp_stat;
        count = $urandom;
        for (int i = 0; i < 3200; i++) begin
            exp_stat = {mq.size() != 0, mq.size() == DEPTH, m_ovf, 8'(m_drops)};
            vectors++;
            if ({ts_valid, fifo_full, overflow, drop_cnt} !== exp_stat) begin
                miscompares++;
                $display("FAIL random_status@%0d: got v/f/o/d=%b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                         ts_valid, fifo_full, overflow, drop_cnt,
                         exp_stat[10], exp_stat[9], exp_stat[8], exp_stat[7:0]);
            end
            if (mq.size() != 0) begin
                vectors++;
                if (ts_data !== mq[0]) begin
                    miscompares++;
                    $display("FAIL random_data@%0d: got %h expected %h", i, ts_data, mq[0]);
                end
            end
            case ((i / 400) % 4)
                0: rd_pct = 30;
                1: rd_pct = 0;
                2: rd_pct = 60;
                default: rd_pct = 10;
            endcase
            phase_left--;
            if (phase_left == 0) begin
                evt = ~evt;
                phase_left = $urandom_range(2, 6);
            end
            rd_en   = ($urandom_range(0, 99) < rd_pct);
            ovf_clr = ($urandom_range(0, 39) == 0);
            tick();
        end
        evt = 1'b0;
        rd_en = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst_drain();
        test_overflow();
        test_full_pop_write();
        test_wrap();
        test_drop_saturation();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
